// File: rtl/rgb_rainbow_sequencer_pkg.sv
// Shared types and helpers for the rainbow breathing-light sequencer.
// Optional breathing envelope is built when BREATH_EN is defined.
package rgb_rainbow_sequencer_pkg;

  typedef logic [7:0] duty_t;

  localparam duty_t DUTY_MAX = 8'd255;

  typedef enum logic [2:0] {
    S_RG_UP = 3'd0,
    S_GR_DN = 3'd1,
    S_GB_UP = 3'd2,
    S_BG_DN = 3'd3,
    S_BR_UP = 3'd4,
    S_RB_DN = 3'd5
  } hue_state_e;

  typedef struct packed {
    duty_t r;
    duty_t g;
    duty_t b;
  } rgb_t;

  function automatic hue_state_e next_hue(input hue_state_e s);
    case (s)
      S_RG_UP: next_hue = S_GR_DN;
      S_GR_DN: next_hue = S_GB_UP;
      S_GB_UP: next_hue = S_BG_DN;
      S_BG_DN: next_hue = S_BR_UP;
      S_BR_UP: next_hue = S_RB_DN;
      default: next_hue = S_RG_UP;
    endcase
  endfunction

  // Each segment holds one channel at full, ramps one, and keeps one dark.
  function automatic rgb_t hue_to_rgb(input hue_state_e s, input duty_t ramp);
    rgb_t c;
    c = '0;
    case (s)
      S_RG_UP: begin c.r = DUTY_MAX;        c.g = ramp;            c.b = 8'd0;            end
      S_GR_DN: begin c.r = DUTY_MAX - ramp; c.g = DUTY_MAX;        c.b = 8'd0;            end
      S_GB_UP: begin c.r = 8'd0;            c.g = DUTY_MAX;        c.b = ramp;            end
      S_BG_DN: begin c.r = 8'd0;            c.g = DUTY_MAX - ramp; c.b = DUTY_MAX;        end
      S_BR_UP: begin c.r = ramp;            c.g = 8'd0;            c.b = DUTY_MAX;        end
      S_RB_DN: begin c.r = DUTY_MAX;        c.g = 8'd0;            c.b = DUTY_MAX - ramp; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rgb_rainbow_sequencer_breath_env.sv
// Triangular breathing envelope: prescaler plus env/dir generator.
// The env output is the value env holds after the coming clock edge.
module rgb_breath_env
  import rgb_rainbow_sequencer_pkg::*;
#(
  parameter int ENV_DIV = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  tick,
  output duty_t env
);

  localparam logic [7:0] PRESC_MAX = 8'(ENV_DIV - 1);

  logic [7:0] presc_q, presc_d;
  duty_t      env_q, env_d;
  logic       dir_up_q, dir_up_d;
  logic       env_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= 8'd0;
      env_q    <= 8'd0;
      dir_up_q <= 1'b1;
    end else begin
      presc_q  <= presc_d;
      env_q    <= env_d;
      dir_up_q <= dir_up_d;
    end
  end

  // The direction flips on the step that lands on an end value, so that end
  // value persists for one full envelope step before moving away.
  always_comb begin
    presc_d  = presc_q;
    env_d    = env_q;
    dir_up_d = dir_up_q;
    env_step = tick && (presc_q == PRESC_MAX);
    if (tick) presc_d = env_step ? 8'd0 : presc_q + 8'd1;
    if (env_step) begin
      if (dir_up_q) begin
        env_d = env_q + 8'd1;
        if (env_d == DUTY_MAX) dir_up_d = 1'b0;
      end else begin
        env_d = env_q - 8'd1;
        if (env_d == 8'd0) dir_up_d = 1'b1;
      end
    end
  end

  assign env = env_d;

endmodule

// File: rtl/rgb_rainbow_sequencer.sv
// Hue-wheel sequencer producing registered R/G/B duty values for the PWM stage.
// Define BREATH_EN to scale the hue by a triangular breathing envelope.
module rgb_rainbow_sequencer
  import rgb_rainbow_sequencer_pkg::*;
#(
  parameter int HUE_STEP = 1,
  parameter int ENV_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_tick,
  input  logic       hold,
  output duty_t      R_time_out,
  output duty_t      G_time_out,
  output duty_t      B_time_out,
  output logic       upd,
  output hue_state_e dbg_state
);

  // Handshake: a tick is consumed in any cycle with step_tick=1 and hold=0;
  // there is no back-pressure and a tick seen under hold is discarded.

  localparam logic [8:0] STEP9 = 9'(HUE_STEP);

  logic       tick_acc;
  hue_state_e state_q, state_d;
  duty_t      ramp_q, ramp_d;
  logic [8:0] ramp_sum;
  rgb_t       hue_d;
  rgb_t       out_d;

  assign tick_acc  = step_tick & ~hold;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RG_UP;
      ramp_q  <= 8'd0;
    end else if (tick_acc) begin
      state_q <= state_d;
      ramp_q  <= ramp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ramp_d   = ramp_q;
    ramp_sum = {1'b0, ramp_q} + STEP9;
    if (ramp_q == DUTY_MAX) begin
      state_d = next_hue(state_q);
      ramp_d  = 8'd0;
    end else begin
      ramp_d = ramp_sum[8] ? DUTY_MAX : ramp_sum[7:0];
    end
  end

  assign hue_d = hue_to_rgb(state_d, ramp_d);

`ifdef BREATH_EN
  duty_t       env;
  logic [8:0]  env_p1;
  logic [15:0] prod_r, prod_g, prod_b;

  rgb_breath_env #(.ENV_DIV(ENV_DIV)) u_breath_env (
    .clk   (clk),
    .rst_n (rst),
    .tick  (tick_acc),
    .env   (env)
  );

  // env+1 spans 1..256, so env=255 passes the hue through and env=0 blanks it.
  always_comb begin
    env_p1 = {1'b0, env} + 9'd1;
    prod_r = 16'(hue_d.r) * 16'(env_p1);
    prod_g = 16'(hue_d.g) * 16'(env_p1);
    prod_b = 16'(hue_d.b) * 16'(env_p1);
    out_d.r = prod_r[15:8];
    out_d.g = prod_g[15:8];
    out_d.b = prod_b[15:8];
  end
`else
  assign out_d = hue_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      R_time_out <= 8'd0;
      G_time_out <= 8'd0;
      B_time_out <= 8'd0;
      upd        <= 1'b0;
    end else begin
      upd <= tick_acc;
      if (tick_acc) begin
        R_time_out <= out_d.r;
        G_time_out <= out_d.g;
        B_time_out <= out_d.b;
      end
    end
  end

endmodule

// File: tb/tb_rgb_rainbow_sequencer.sv
// Bench for rgb_rainbow_sequencer: default instance plus HUE_STEP=100/ENV_DIV=1 instance.
// Expected values come from a tick-count based model of the hue wheel and envelope.
module tb_rgb_rainbow_sequencer;
  import rgb_rainbow_sequencer_pkg::*;

`ifdef BREATH_EN
  localparam bit BREATH = 1'b1;
`else
  localparam bit BREATH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic step_tick;
  logic hold;
  duty_t a_r, a_g, a_b, b_r, b_g, b_b;
  logic a_upd, b_upd;
  hue_state_e a_st, b_st;

  int errors = 0;
  int checks = 0;
  int unsigned n = 0;

  always #5 clk = ~clk;

  rgb_rainbow_sequencer u_dut_a (
    .clk(clk), .rst(rst), .step_tick(step_tick), .hold(hold),
    .R_time_out(a_r), .G_time_out(a_g), .B_time_out(a_b),
    .upd(a_upd), .dbg_state(a_st)
  );

  rgb_rainbow_sequencer #(.HUE_STEP(100), .ENV_DIV(1)) u_dut_b (
    .clk(clk), .rst(rst), .step_tick(step_tick), .hold(hold),
    .R_time_out(b_r), .G_time_out(b_g), .B_time_out(b_b),
    .upd(b_upd), .dbg_state(b_st)
  );

  typedef struct { int r; int g; int b; } tb_rgb_t;
  typedef struct { bit st; bit hd; bit exp_upd; } vec_t;

  // Wheel position after n ticks: each segment lasts ceil(255/step)+1 ticks.
  function automatic int model_seg(input int unsigned cnt, input int step);
    int len;
    len = (255 + step - 1) / step + 1;
    return (cnt % (6 * len)) / len;
  endfunction

  function automatic tb_rgb_t model_rgb(input int unsigned cnt, input int step, input int div);
    tb_rgb_t c;
    int len, k, ramp, e, env;
    c = '{0, 0, 0};
    if (cnt == 0) return c;
    len  = (255 + step - 1) / step + 1;
    k    = (cnt % (6 * len)) % len;
    ramp = (k * step > 255) ? 255 : k * step;
    case (model_seg(cnt, step))
      0: c = '{255, ramp, 0};
      1: c = '{255 - ramp, 255, 0};
      2: c = '{0, 255, ramp};
      3: c = '{0, 255 - ramp, 255};
      4: c = '{ramp, 0, 255};
      default: c = '{255, 0, 255 - ramp};
    endcase
    if (BREATH) begin
      e   = (cnt / div) % 510;
      env = (e <= 255) ? e : 510 - e;
      c.r = (c.r * (env + 1)) / 256;
      c.g = (c.g * (env + 1)) / 256;
      c.b = (c.b * (env + 1)) / 256;
    end
    return c;
  endfunction

  task automatic check(input string tag, input string what, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", tag, what, act, exp);
    end
  endtask

  task automatic compare_dut(input string tag, input bit exp_upd);
    tb_rgb_t ea, eb;
    ea = model_rgb(n, 1, 4);
    eb = model_rgb(n, 100, 1);
    check(tag, "a_r", int'(a_r), ea.r);
    check(tag, "a_g", int'(a_g), ea.g);
    check(tag, "a_b", int'(a_b), ea.b);
    check(tag, "a_upd", int'(a_upd), int'(exp_upd));
    check(tag, "a_state", int'(a_st), model_seg(n, 1));
    check(tag, "b_r", int'(b_r), eb.r);
    check(tag, "b_g", int'(b_g), eb.g);
    check(tag, "b_b", int'(b_b), eb.b);
    check(tag, "b_upd", int'(b_upd), int'(exp_upd));
    check(tag, "b_state", int'(b_st), model_seg(n, 100));
  endtask

  task automatic drive_cycle(input bit st, input bit hd);
    step_tick = st;
    hold      = hd;
    @(posedge clk);
    #1;
    if (st && !hd) n++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step_tick = 1'b0;
    hold = 1'b0;
    @(posedge clk);
    #1;
    n = 0;
    rst = 1'b1;
  endtask

  vec_t vt[16];

  initial begin
    for (int i = 0; i < 10; i++) vt[i] = '{1'b1, 1'b1, 1'b0};
    vt[10] = '{1'b1, 1'b0, 1'b1};
    vt[11] = '{1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b1, 1'b0};
    vt[13] = '{1'b1, 1'b0, 1'b1};
    vt[14] = '{1'b1, 1'b0, 1'b1};
    vt[15] = '{1'b0, 1'b0, 1'b0};

    // Reset state, then the first tick after release.
    rst = 1'b0; step_tick = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare_dut("in_reset", 1'b0);
    rst = 1'b1;
    drive_cycle(1'b0, 1'b0);
    compare_dut("idle", 1'b0);
    drive_cycle(1'b1, 1'b0);
    compare_dut("first_tick", 1'b1);
    if (!BREATH) begin
      check("first_tick", "hand_r", int'(a_r), 255);
      check("first_tick", "hand_g", int'(a_g), 1);
      check("first_tick", "hand_b", int'(a_b), 0);
    end
    drive_cycle(1'b0, 1'b0);
    compare_dut("after_first", 1'b0);

    // Hold with tick, release, single steps.
    for (int i = 0; i < 16; i++) begin
      drive_cycle(vt[i].st, vt[i].hd);
      compare_dut($sformatf("vec%0d", i), vt[i].exp_upd);
    end

    // Asynchronous reset mid-segment, seen before the next edge.
    repeat (40) drive_cycle(1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("async_rst", "a_r", int'(a_r), 0);
    check("async_rst", "a_g", int'(a_g), 0);
    check("async_rst", "b_r", int'(b_r), 0);
    check("async_rst", "a_upd", int'(a_upd), 0);
    check("async_rst", "a_state", int'(a_st), 0);
    step_tick = 1'b0;
    @(posedge clk);
    #1;
    n = 0;
    rst = 1'b1;
    drive_cycle(1'b1, 1'b0);
    compare_dut("post_rst_tick", 1'b1);
    if (!BREATH) begin
      check("post_rst_tick", "hand_r", int'(a_r), 255);
      check("post_rst_tick", "hand_g", int'(a_g), 1);
    end else begin
      check("post_rst_tick", "hand_r", int'(a_r), 0);
    end

    // Saturating ramp with HUE_STEP=100.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      int exp_g[4];
      exp_g = '{100, 200, 255, 255};
      drive_cycle(1'b1, 1'b0);
      compare_dut($sformatf("sat%0d", i), 1'b1);
      if (!BREATH) check($sformatf("sat%0d", i), "hand_b_g", int'(b_g), exp_g[i-1]);
    end
    check("sat4", "b_state", int'(b_st), 1);
    if (!BREATH) check("sat4", "hand_b_r", int'(b_r), 255);

    // Continuous ticking over one full default revolution.
    do_reset();
    for (int i = 1; i <= 1536; i++) begin
      drive_cycle(1'b1, 1'b0);
      compare_dut("cont", 1'b1);
      if (!BREATH && n <= 255) check("cont", "g_ramp", int'(a_g), int'(n));
      if (n == 256) begin
        check("rev256", "a_state", int'(a_st), 1);
        if (!BREATH) begin
          check("rev256", "hand_r", int'(a_r), 255);
          check("rev256", "hand_g", int'(a_g), 255);
          check("rev256", "hand_b", int'(a_b), 0);
        end
      end
      if (BREATH && n == 510) begin
        check("env_zero", "b_r", int'(b_r), 0);
        check("env_zero", "b_g", int'(b_g), 0);
        check("env_zero", "b_b", int'(b_b), 0);
      end
    end
    check("rev1536", "a_state", int'(a_st), 0);
    if (!BREATH) begin
      check("rev1536", "hand_r", int'(a_r), 255);
      check("rev1536", "hand_g", int'(a_g), 0);
      check("rev1536", "hand_b", int'(a_b), 0);
    end

    // Random tick/hold traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit st, hd;
      st = 1'($urandom_range(0, 1));
      hd = ($urandom_range(0, 3) == 0);
      drive_cycle(st, hd);
      compare_dut("rand", st && !hd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
